// File: rtl/ifmap_spad_ctrl_if.sv
// Stream and control bundle between the ifmap scratchpad controller and its neighbours:
// config/start, the ifmap fill stream in, and the PE operand stream out.
interface ifmap_spad_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [ADDR_W-1:0] cfg_win;
    logic [ADDR_W-1:0] cfg_stride;
    logic [ADDR_W-1:0] cfg_nwin;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        output start, cfg_win, cfg_stride, cfg_nwin,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  start, cfg_win, cfg_stride, cfg_nwin,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/ifmap_spad_ctrl.sv
// Ifmap scratchpad controller: fills DEPTH words from the ifmap stream, then replays
// cfg_nwin+1 sliding windows of cfg_win+1 words, advancing the window base by cfg_stride.
module ifmap_spad_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    ifmap_spad_ctrl_if.slave  bus,
    output logic [ADDR_W-1:0] spad_addr,
    output logic              spad_we,
    inout  wire  [DATA_W-1:0] spad_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        READ,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] off_q, off_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] win_q, stride_q, nwin_q;
    logic              cfg_load;
    logic              win_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            fill_q  <= '0;
            base_q  <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            base_q  <= base_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
        end
    end

    // Config is frozen for the whole pass once start is accepted.
    always_ff @(posedge clk) begin
        if (cfg_load) begin
            win_q    <= bus.cfg_win;
            stride_q <= bus.cfg_stride;
            nwin_q   <= bus.cfg_nwin;
        end
    end

    assign cfg_load = (state_q == IDLE) && bus.start && !rst;
    assign win_last = (off_q == win_q);

    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        base_d        = base_q;
        off_d         = off_q;
        cnt_d         = cnt_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.done      = 1'b0;
        spad_we       = 1'b0;
        spad_addr     = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FILL;
                    fill_d  = '0;
                    base_d  = '0;
                    off_d   = '0;
                    cnt_d   = '0;
                end
            end

            FILL: begin
                bus.in_ready = 1'b1;
                spad_we      = bus.in_valid;
                spad_addr    = fill_q;
                if (bus.in_valid) begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == LAST_ADDR) begin
                        state_d = READ;
                    end
                end
            end

            READ: begin
                bus.out_valid = 1'b1;
                bus.out_last  = win_last;
                spad_addr     = base_q + off_q;
                if (bus.out_ready) begin
                    if (win_last) begin
                        off_d  = '0;
                        base_d = base_q + stride_q;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == nwin_q) begin
                            state_d = DONE;
                        end
                    end else begin
                        off_d = off_q + 1'b1;
                    end
                end
            end

            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // The scratchpad owns the data port except while we are writing it.
    assign spad_data    = spad_we ? bus.in_data : {DATA_W{1'bz}};
    assign bus.out_data = spad_data;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ifmap_spad_ctrl.sv
// Scoreboard bench for ifmap_spad_ctrl with a behavioural scratchpad on the tri-state port.
module tb_ifmap_spad_ctrl;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifmap_spad_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    logic [ADDR_W-1:0] spad_addr;
    logic              spad_we;
    wire  [DATA_W-1:0] spad_data;
    logic [DATA_W-1:0] mem [DEPTH];

    assign spad_data = spad_we ? {DATA_W{1'bz}} : mem[spad_addr];
    always @(posedge clk) if (spad_we) mem[spad_addr] <= spad_data;

    ifmap_spad_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .spad_addr(spad_addr),
        .spad_we  (spad_we),
        .spad_data(spad_data)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_idle_outputs(input string tag);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", tag, bus.busy); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready: got %b want 0", tag, bus.in_ready); end
        checks++; if (spad_we !== 1'b0) begin errors++; $display("FAIL %s spad_we: got %b want 0", tag, spad_we); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid: got %b want 0", tag, bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL %s out_last: got %b want 0", tag, bus.out_last); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done: got %b want 0", tag, bus.done); end
        checks++; if (spad_addr !== '0) begin errors++; $display("FAIL %s spad_addr: got %h want 0", tag, spad_addr); end
    endtask

    // One full pass (or an aborted one); expectations derived from the fill words and config.
    task automatic run_pass(input logic [3:0] w, input logic [3:0] s, input logic [3:0] n,
                            input bit rand_words, input bit gaps, input bit bp,
                            input int abort_fill, input int abort_out, input bit poke_start);
        logic [DATA_W-1:0] words [16];
        logic [DATA_W-1:0] hold_d;
        logic [ADDR_W-1:0] hold_a;
        exp_t e;
        int   total, fill_idx, out_cnt, cyc;
        bit   exp_done, finished, hold_v;

        for (int i = 0; i < 16; i++) words[i] = rand_words ? DATA_W'($urandom) : 16'h1000 + 16'(i);
        sb.delete();
        for (int wi = 0; wi <= int'(n); wi++) begin
            for (int o = 0; o <= int'(w); o++) begin
                e.addr = 4'((wi * int'(s) + o) % 16);
                e.data = words[e.addr];
                e.last = (o == int'(w));
                sb.push_back(e);
            end
        end
        total = sb.size();

        bus.start      = 1'b1;
        bus.cfg_win    = w;
        bus.cfg_stride = s;
        bus.cfg_nwin   = n;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.cfg_win    = ~w;
        bus.cfg_stride = s + 4'd3;
        bus.cfg_nwin   = ~n;

        fill_idx = 0; out_cnt = 0; cyc = 0;
        exp_done = 1'b0; finished = 1'b0; hold_v = 1'b0;
        hold_d = '0; hold_a = '0;
        while (!finished && cyc < 3000) begin
            cyc++;
            bus.in_valid  = (fill_idx < 16) && (!gaps || $urandom_range(0, 2) != 0);
            bus.in_data   = words[fill_idx % 16];
            bus.out_ready = !bp || ($urandom_range(0, 1) == 1);
            bus.start     = poke_start && (cyc == 4 || (out_cnt == 2 && bus.out_valid === 1'b1));
            @(negedge clk);

            if (exp_done) begin
                checks++;
                if (bus.done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b want 1", bus.done); end
                finished = 1'b1;
            end else if (bus.done !== 1'b0) begin
                checks++; errors++;
                $display("FAIL early_done: got %b want 0 after %0d words", bus.done, out_cnt);
            end

            if (hold_v) begin
                checks++;
                if (bus.out_data !== hold_d || spad_addr !== hold_a)
                    begin errors++; $display("FAIL hold_stable: got %h@%h want %h@%h", bus.out_data, spad_addr, hold_d, hold_a); end
            end
            hold_v = 1'b0;

            if (bus.in_ready === 1'b1 && !bus.in_valid) begin
                checks++;
                if (spad_we !== 1'b0) begin errors++; $display("FAIL idle_write: got spad_we=%b want 0", spad_we); end
            end
            if (bus.in_ready === 1'b1 && bus.in_valid) begin
                checks++;
                if (spad_we !== 1'b1 || spad_addr !== 4'(fill_idx))
                    begin errors++; $display("FAIL fill_write: got we=%b addr=%h want we=1 addr=%h", spad_we, spad_addr, 4'(fill_idx)); end
                fill_idx++;
            end

            if (bus.out_valid === 1'b1) begin
                if (bus.out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++; $display("FAIL extra_word: got %h with empty scoreboard", bus.out_data);
                    end else begin
                        e = sb.pop_front();
                        if (bus.out_data !== e.data || bus.out_last !== e.last || spad_addr !== e.addr)
                            begin errors++; $display("FAIL word_%0d: got %h last=%b addr=%h want %h last=%b addr=%h", out_cnt, bus.out_data, bus.out_last, spad_addr, e.data, e.last, e.addr); end
                        out_cnt++;
                        if (sb.size() == 0) exp_done = 1'b1;
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_d = bus.out_data;
                    hold_a = spad_addr;
                end
            end

            if ((abort_fill >= 0 && fill_idx == abort_fill) || (abort_out > 0 && out_cnt == abort_out)) begin
                @(posedge clk); #1;
                rst           = 1'b1;
                bus.in_valid  = 1'b1;
                bus.out_ready = 1'b1;
                bus.start     = 1'b1;
                @(posedge clk); #1;
                rst       = 1'b0;
                bus.start = 1'b0;
                @(negedge clk);
                check_idle_outputs("abort");
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    checks++;
                    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
                        begin errors++; $display("FAIL abort_quiet: got done=%b busy=%b want 0 0", bus.done, bus.busy); end
                end
                @(posedge clk); #1;
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b0;
                sb.delete();
                return;
            end
            @(posedge clk); #1;
        end

        if (!finished) begin
            errors++; checks++;
            $display("FAIL timeout: got %0d words want %0d", out_cnt, total);
        end
        checks++;
        if (out_cnt != total) begin errors++; $display("FAIL word_count: got %0d want %0d", out_cnt, total); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL after_done: got done=%b busy=%b want 0 0", bus.done, bus.busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.start      = 1'b1;
        bus.cfg_win    = 4'd2;
        bus.cfg_stride = 4'd1;
        bus.cfg_nwin   = 4'd2;
        bus.in_valid   = 1'b1;
        bus.in_data    = 16'hBEEF;
        bus.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_start_priority: got busy=%b want 0", bus.busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_pass(4'd2, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_wrap();
        run_pass(4'd3, 4'd7, 4'd2, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_pass(4'd4, 4'd5, 4'd3, 1'b1, 1'b1, 1'b1, -1, -1, 1'b0);
        run_pass(4'd2, 4'd1, 4'd2, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_pass(4'd2, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1);
    endtask

    task automatic test_reset_mid_pass();
        run_pass(4'd2, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 5, -1, 1'b0);
        run_pass(4'd3, 4'd2, 4'd3, 1'b1, 1'b0, 1'b1, -1, 4, 1'b0);
        run_pass(4'd2, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_pass(4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 1'b1, -1, -1, 1'b0);
        run_pass(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0);
        run_pass(4'd5, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.cfg_win    = '0;
        bus.cfg_stride = '0;
        bus.cfg_nwin   = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_pass();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
